// File: rtl/log2_fmt_pkg.sv
// Shared types for the log2 BCD formatter.
// State encoding, BCD digit type and constants.
package log2_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } fmt_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_TEN = 4'd10;

endpackage

// File: rtl/frac_x10_step.sv
// One fraction-to-decimal step: acc*10 by shift-add.
// The top nibble is the next digit; the low bits carry on.
module frac_x10_step
  import log2_fmt_pkg::*;
#(
  parameter int FRAC_W = 15
) (
  input  logic [FRAC_W-1:0] acc,
  output bcd_t              digit,
  output logic [FRAC_W-1:0] acc_next
);

  logic [FRAC_W+3:0] ext;
  logic [FRAC_W+3:0] p;

  assign ext      = {4'b0, acc};
  assign p        = (ext << 3) + (ext << 1);
  assign digit    = p[FRAC_W+3:FRAC_W];
  assign acc_next = p[FRAC_W-1:0];

endmodule

// File: rtl/log2_bcd_formatter.sv
// Captures a log2 result on the done edge and emits
// it as BCD on a valid/ready handshake.
module log2_bcd_formatter
  import log2_fmt_pkg::*;
#(
  parameter int FRAC_W = 15,
  parameter int NDIG   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  done_i,
  input  logic [3:0]            int_i,
  input  logic [15:0]           frac_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [4*(2+NDIG)-1:0] dec_o
);

  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  fmt_state_e        state;
  logic              done_q;
  logic              start;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;
  bcd_t              digit;
  bcd_t              tens;
  bcd_t              ones;
  logic              unused_frac;

  assign start       = done_i & ~done_q;
  assign unused_frac = ^frac_i;

  assign tens = (int_i >= BCD_TEN) ? 4'd1 : 4'd0;
  assign ones = (int_i >= BCD_TEN) ? int_i - BCD_TEN : int_i;

  frac_x10_step #(
    .FRAC_W(FRAC_W)
  ) u_step (
    .acc     (acc),
    .digit   (digit),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      dec_o   <= '0;
    end else begin
      done_q <= done_i;
      unique case (state)
        IDLE: begin
          if (start) begin
            dec_o[4*NDIG +: 8] <= {tens, ones};
            acc    <= frac_i[FRAC_W-1:0];
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          // d1 (0.1 weight) sits just below the integer digits
          for (int i = 0; i < NDIG; i++) begin
            if (cnt == CNT_W'(i)) begin
              dec_o[4*(NDIG-1-i) +: 4] <= digit;
            end
          end
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            valid_o <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_bcd_formatter.sv
// Directed and pseudo-random checks of log2_bcd_formatter.
// Expected BCD comes from hand values and a floor model.
module tb_log2_bcd_formatter;

  localparam int FRAC_W = 15;
  localparam int NDIG   = 4;
  localparam int DW     = 4*(2+NDIG);

  logic          clk_i   = 1'b0;
  logic          rst_i   = 1'b0;
  logic          done_i  = 1'b0;
  logic [3:0]    int_i   = '0;
  logic [15:0]   frac_i  = '0;
  logic          ready_i = 1'b0;
  logic          busy_o;
  logic          valid_o;
  logic [DW-1:0] dec_o;

  int n_chk  = 0;
  int n_pass = 0;

  log2_bcd_formatter #(
    .FRAC_W(FRAC_W),
    .NDIG  (NDIG)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .done_i (done_i),
    .int_i  (int_i),
    .frac_i (frac_i),
    .ready_i(ready_i),
    .busy_o (busy_o),
    .valid_o(valid_o),
    .dec_o  (dec_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] ref_dec(input logic [3:0] iv,
                                            input logic [15:0] fv);
    longint q;
    logic [DW-1:0] r;
    q = (longint'(fv[FRAC_W-1:0]) * 10000) >> FRAC_W;
    r = '0;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = 4'(q % 10);
      q = q / 10;
    end
    r[4*NDIG +: 4]   = 4'(iv % 10);
    r[4*NDIG+4 +: 4] = 4'(iv / 10);
    return r;
  endfunction

  // capture, wait to edge 5, check result; leaves DUT in HOLD
  task automatic conv_to_hold(input string tag,
                              input logic [3:0] iv,
                              input logic [15:0] fv,
                              input logic [DW-1:0] exp);
    ready_i = 1'b0;
    int_i   = iv;
    frac_i  = fv;
    done_i  = 1'b1;
    tick();
    check({tag, "_busy1"}, 32'(busy_o), 32'd1);
    done_i = 1'b0;
    repeat (3) tick();
    check({tag, "_valid_e4"}, 32'(valid_o), 32'd0);
    tick();
    check({tag, "_valid_e5"}, 32'(valid_o), 32'd1);
    check({tag, "_dec"}, 32'(dec_o), 32'(exp));
  endtask

  task automatic handshake(input string tag);
    ready_i = 1'b1;
    tick();
    check({tag, "_valid_off"}, 32'(valid_o), 32'd0);
    check({tag, "_busy_off"}, 32'(busy_o), 32'd0);
    ready_i = 1'b0;
  endtask

  initial begin
    int vcnt;
    logic [DW-1:0] got;
    logic [3:0] ri;
    logic [15:0] rf;

    repeat (2) tick();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_dec", 32'(dec_o), 32'd0);
    #3 rst_i = 1'b1;
    tick();

    conv_to_hold("log10", 4'd3, 16'h2934, 24'h033218);
    handshake("log10");
    conv_to_hold("max", 4'd15, 16'h7FFF, 24'h159999);
    handshake("max");
    conv_to_hold("ten", 4'd10, 16'h4000, 24'h105000);
    handshake("ten");
    conv_to_hold("ign_hi", 4'd1, 16'hC000, 24'h015000);
    handshake("ign_hi");

    conv_to_hold("zero", 4'd0, 16'h0000, 24'h000000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_dec", 32'(dec_o), 32'h000000);
    end
    handshake("zero");

    // done edge during CONV, then done held high
    int_i  = 4'd3;
    frac_i = 16'h2934;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    done_i = 1'b1;
    tick();
    tick();
    tick();
    check("retrig_valid", 32'(valid_o), 32'd1);
    check("retrig_dec", 32'(dec_o), 32'h033218);
    ready_i = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_o) vcnt++;
    end
    check("retrig_none", 32'(vcnt), 32'd0);
    check("retrig_busy", 32'(busy_o), 32'd0);
    done_i = 1'b0;
    tick();
    conv_to_hold("fresh", 4'd9, 16'h6000, 24'h097500);
    handshake("fresh");

    // async reset with cnt=2
    int_i  = 4'd7;
    frac_i = 16'h1234;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    tick();
    #2 rst_i = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_dec", 32'(dec_o), 32'd0);
    #2 rst_i = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_o || busy_o) vcnt++;
    end
    check("arst_quiet", 32'(vcnt), 32'd0);

    // back-to-back with ready tied high
    ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      ri     = 4'($urandom_range(0, 15));
      rf     = 16'($urandom);
      int_i  = ri;
      frac_i = rf;
      done_i = 1'b1;
      tick();
      vcnt = valid_o ? 1 : 0;
      got  = '0;
      done_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
        tick();
        if (valid_o) begin
          vcnt++;
          got = dec_o;
        end
      end
      check("b2b_pulse", 32'(vcnt), 32'd1);
      check("b2b_dec", 32'(got), 32'(ref_dec(ri, rf)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
